// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory stage: access sizes, funct3 codes,
// the control word from execute and the stage state encoding.
package memory_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } control_type;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_RESP = 2'b10
    } stage_state_e;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory port: request/grant for the address phase, rvalid for read data.
interface memory_stage_if;
    import memory_stage_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [BE_W-1:0] dmem_be;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/memory_stage_load_store_align.sv
// Byte-lane logic: store enables/replication, load extraction and the
// alignment check, all derived from funct3 and the low address bits.
module load_store_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [BE_W-1:0] be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_val,
    output logic            misaligned
);

    logic [XLEN-1:0] lane;

    always_comb begin
        lane       = rdata >> {addr_lo, 3'b000};
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = 1'b0;
        load_val   = rdata;

        // Size 11 falls through to word handling
        case (funct3[1:0])
            MEM_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            MEM_H: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            default: misaligned = |addr_lo;
        endcase

        case (funct3)
            F3_LB:   load_val = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   load_val = {{16{lane[15]}}, lane[15:0]};
            F3_LBU:  load_val = {24'b0, lane[7:0]};
            F3_LHU:  load_val = {16'b0, lane[15:0]};
            default: load_val = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: runs loads/stores on the data-memory port, stalls
// upstream until each access completes and registers results for writeback.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  control_type     control_in,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    output logic            stall,
    output logic            out_valid,
    output control_type     control_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] mem_data,
    output logic            misaligned,
    output logic            bus_error,
    memory_stage_if.master  dmem
);

    localparam int unsigned WD_W = 32;

    stage_state_e    state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0] be_q, be_d;

    logic            out_valid_q, out_valid_d;
    control_type     control_out_q, control_out_d;
    logic [XLEN-1:0] alu_out_q, alu_out_d;
    logic [XLEN-1:0] mem_data_q, mem_data_d;
    logic            mis_q, mis_d;
    logic            berr_q, berr_d;

    logic            is_mem;
    logic            timeout;
    logic            done;
    logic            fin_mis;
    logic            fin_err;
    logic [XLEN-1:0] fin_data;

    logic [2:0]      al_funct3;
    logic [1:0]      al_addr_lo;
    logic [BE_W-1:0] al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_load;
    logic            al_mis;

    // Lane logic sees live inputs while idle and the latched access afterwards
    assign al_funct3  = (state_q == S_IDLE) ? funct3 : funct3_q;
    assign al_addr_lo = (state_q == S_IDLE) ? alu_result[1:0] : addr_lo_q;

    load_store_align u_align (
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .store_data (store_data),
        .rdata      (dmem.dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_val   (al_load),
        .misaligned (al_mis)
    );

    assign is_mem  = in_valid && (control_in.mem_read || control_in.mem_write);
    assign timeout = (MAX_WAIT != 0) && (state_q != S_IDLE)
                     && (wd_q == WD_W'(MAX_WAIT) - WD_W'(1));

    always_comb begin
        state_d       = state_q;
        wd_d          = '0;
        funct3_d      = funct3_q;
        addr_lo_d     = addr_lo_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        out_valid_d   = 1'b0;
        control_out_d = control_out_q;
        alu_out_d     = alu_out_q;
        mem_data_d    = mem_data_q;
        mis_d         = mis_q;
        berr_d        = berr_q;
        done          = 1'b0;
        fin_mis       = 1'b0;
        fin_err       = 1'b0;
        fin_data      = '0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_mem && !al_mis) begin
                        state_d   = S_REQ;
                        we_d      = control_in.mem_write;
                        addr_d    = {alu_result[XLEN-1:2], 2'b00};
                        be_d      = control_in.mem_write ? al_be : 4'b1111;
                        wdata_d   = al_wdata;
                        funct3_d  = funct3;
                        addr_lo_d = alu_result[1:0];
                    end else begin
                        done    = 1'b1;
                        fin_mis = is_mem;
                    end
                end
            end
            S_REQ: begin
                wd_d = wd_q + WD_W'(1);
                if (dmem.dmem_gnt) begin
                    if (we_q) done = 1'b1;
                    else      state_d = S_RESP;
                end
            end
            S_RESP: begin
                wd_d = wd_q + WD_W'(1);
                if (dmem.dmem_rvalid) begin
                    done     = 1'b1;
                    fin_data = al_load;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Watchdog abort only when the bus did not complete this cycle
        if (timeout && !done) begin
            done     = 1'b1;
            fin_err  = 1'b1;
            fin_data = '0;
        end

        if (done) begin
            state_d       = S_IDLE;
            wd_d          = '0;
            out_valid_d   = 1'b1;
            control_out_d = control_in;
            alu_out_d     = alu_result;
            mem_data_d    = fin_data;
            mis_d         = fin_mis;
            berr_d        = fin_err;
        end

        req_d = (state_d == S_REQ);
        stall = is_mem && !al_mis && !done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            wd_q          <= '0;
            funct3_q      <= '0;
            addr_lo_q     <= '0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            out_valid_q   <= 1'b0;
            control_out_q <= '0;
            alu_out_q     <= '0;
            mem_data_q    <= '0;
            mis_q         <= 1'b0;
            berr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            funct3_q      <= funct3_d;
            addr_lo_q     <= addr_lo_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            out_valid_q   <= out_valid_d;
            control_out_q <= control_out_d;
            alu_out_q     <= alu_out_d;
            mem_data_q    <= mem_data_d;
            mis_q         <= mis_d;
            berr_q        <= berr_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    assign out_valid      = out_valid_q;
    assign control_out    = control_out_q;
    assign alu_result_out = alu_out_q;
    assign mem_data       = mem_data_q;
    assign misaligned     = mis_q;
    assign bus_error      = berr_q;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Pipeline stage downstream of the execute stage. It consumes the ALU result as a data address, or passes it through, together with the store operand and control word. Loads and stores run against a data-memory port with a req/gnt/rvalid handshake. The stage stalls the upstream pipeline until each access completes. It delivers a registered, aligned and sign/zero-extended load value plus pass-through ALU result and control to writeback.

Parameters:
MAX_WAIT, 0, watchdog limit in cycles spent in REQ+RESP for one access; 0 disables the watchdog.

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  execute stage presents a valid instruction
control_in  input  control_type  control word from execute; fields mem_read, mem_write used here
funct3  input  3  access size/sign (RV32I load/store funct3)
alu_result  input  32  address for mem ops, pass-through value otherwise
store_data  input  32  rs2 value for stores
stall  output  1  hold upstream; instruction not consumed this cycle
out_valid  output  1  registered: writeback inputs valid
control_out  output  control_type  registered copy of control_in
alu_result_out  output  32  registered copy of alu_result
mem_data  output  32  registered extended load data; 0 for non-loads
misaligned  output  1  registered: access was misaligned, no bus transaction issued
bus_error  output  1  registered: watchdog expired, access aborted
dmem_req  output  1  request, held until dmem_gnt
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address (alu_result[31:2], 2'b00)
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_gnt  input  1  request accepted this cycle
dmem_rvalid  input  1  read data valid this cycle
dmem_rdata  input  32  read data

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE; the watchdog counter clears.
  - All registered outputs go to 0, including control_out = '0.
  - dmem_req drops without waiting for a clock edge.
  - An rvalid arriving after reset is ignored.
- States: IDLE, REQ, RESP.
- is_mem = in_valid & (mem_read | mem_write).
- Alignment:
  - funct3[1:0] = 00 (byte) is always aligned.
  - 01 (half) requires addr[0] = 0.
  - 10 (word) requires addr[1:0] = 0.
  - 11 is treated as word.
- IDLE, non-mem in_valid: out_valid = 1 next edge; control/alu pass through; mem_data = 0; stall = 0.
- IDLE, misaligned mem op: no request; out_valid = 1 and misaligned = 1 next edge; stall = 0.
- IDLE, aligned mem op:
  - stall = 1.
  - Register dmem_addr, dmem_we, dmem_be, dmem_wdata, funct3 and addr[1:0].
  - Go to REQ.
- REQ:
  - dmem_req = 1, with addr, we, be and wdata held stable.
  - On dmem_gnt with a write: done.
  - On dmem_gnt with a read: go to RESP.
- RESP: on dmem_rvalid, done. An rvalid in the same cycle as gnt is not supported; it is sampled only in RESP.
- done (combinational):
  - stall = 0.
  - At the edge: out_valid = 1, mem_data = extracted load value (0 for stores), state goes to IDLE.
- stall = is_mem & aligned & !done, in every state.
- out_valid is a single-cycle pulse per consumed instruction. It is 0 on any cycle where nothing completes, and the registered data outputs hold their previous values.
- Minimum latencies:
  - Non-mem: 1 cycle.
  - Write with gnt on the first REQ cycle: 2 cycles.
  - Read with gnt and rvalid in consecutive cycles: 3 cycles.
- Byte enables and write-data lanes:
  - SB: be = 1 << addr[1:0]; wdata = {4{store_data[7:0]}}.
  - SH: be = 0011 if addr[1] = 0, else 1100; wdata = {2{store_data[15:0]}}.
  - SW: be = 1111.
  - Loads: be = 1111.
- Load extract:
  - Select the byte/half lane using the registered addr[1:0].
  - 000 (LB) and 001 (LH) sign-extend.
  - 100 (LBU) and 101 (LHU) zero-extend.
  - 010 (LW) and all others take the full word.
- Watchdog (MAX_WAIT > 0):
  - The counter increments each cycle in REQ or RESP and clears in IDLE.
  - On reaching MAX_WAIT: done with bus_error = 1 and mem_data = 0; dmem_req drops and the state returns to IDLE.
  - A late rvalid is ignored.
- in_valid deasserting mid-access is illegal; the upstream contract is to hold while stall = 1.

Decomposition:
- Package common:
  - mem_size enumeration and load/store funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - mem_read and mem_write fields of control_type.
  - Stage state enumeration.
- Sub-module load_store_align: purely combinational. It takes funct3, addr[1:0], store_data and rdata and produces be, wdata, load value and misaligned. It is instantiated once.

Test Plan:
- Non-mem ADD result 0x0000_0010 with in_valid -> next cycle out_valid = 1, alu_result_out = 0x10, mem_data = 0, stall never 1.
- SB addr 0x103, store_data 0xAB, gnt on first REQ cycle -> dmem_be = 1000, dmem_wdata = 0xABABABAB, dmem_addr = 0x100, out_valid 2 cycles after issue.
- LB addr 0x102, rdata 0x0080_0000, gnt delayed 3 cycles, rvalid 2 cycles later -> stall high throughout; mem_data = 0xFFFF_FF80. Repeat as LBU -> 0x0000_0080.
- LH addr 0x101 -> no dmem_req; misaligned = 1 and out_valid = 1 next cycle; no stall.
- MAX_WAIT = 4, LW with rvalid never asserted -> bus_error = 1 after 4 cycles in REQ+RESP; dmem_req low; a later rvalid produces no out_valid.
- reset_n pulsed low while in RESP -> dmem_req and out_valid 0 immediately; state IDLE; the next LW completes normally.
